// File: rtl/lms_pkg.sv
// Shared definitions for the parallel-lane LMS adaptive FIR.
//   state_t     : controller states (IDLE accepts, RUN issues taps, DRAIN
//                 flushes the pipeline, OUT holds the result)
//   sat_s       : signed saturation of a wide value to a narrower width
//   idx_width / acc_width : widths derived with $clog2
package lms_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  // Saturation operates on a fixed 128-bit container so one function serves
  // every width in the design; callers narrow the result with a size cast.
  localparam int unsigned SAT_IW = 128;
  localparam int unsigned SAT_OW = 64;

  // Cycles spent in DRAIN so that the result lands TAPS/LANES+4 cycles
  // after the acceptance edge.
  localparam int unsigned DRAIN_CYCLES = 4;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned acc_width(input int unsigned ww, input int unsigned dw,
                                            input int unsigned taps);
    return ww + dw + $clog2(taps);
  endfunction

  // Clamp v to the signed range of w bits (w <= SAT_OW).
  function automatic logic signed [SAT_OW-1:0] sat_s(input logic signed [SAT_IW-1:0] v,
                                                      input int unsigned w);
    logic signed [SAT_IW-1:0] hi;
    logic signed [SAT_IW-1:0] lo;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    lo = -hi - 128'sd1;
    if (v > hi)      sat_s = hi[SAT_OW-1:0];
    else if (v < lo) sat_s = lo[SAT_OW-1:0];
    else             sat_s = v[SAT_OW-1:0];
  endfunction

endpackage

// File: rtl/lms_lane.sv
// One tap-processing lane: leakage, LMS delta, saturated weight update and
// the weight*sample product that feeds the output accumulator.
//   w, x      : current weight and history sample of the tap
//   eu        : error*mu already scaled by >>>FRAC
//   adapt/leak/leak_sh : per-sample controls latched at acceptance
//   w_new     : saturated updated weight (written back by the top)
//   prod      : (w_new*x)>>>FRAC, full precision
module lms_lane import lms_pkg::*; #(
  parameter int DW   = 16,
  parameter int WW   = 32,
  parameter int FRAC = 15
) (
  input  logic signed [WW-1:0]    w,
  input  logic signed [DW-1:0]    x,
  input  logic signed [2*DW-1:0]  eu,
  input  logic                    adapt,
  input  logic                    leak,
  input  logic [3:0]              leak_sh,
  output logic signed [WW-1:0]    w_new,
  output logic signed [WW+DW-1:0] prod
);

  localparam int DPW = 3 * DW;
  // One guard bit over the widest addend plus one for the carry.
  localparam int SW  = ((WW + 1 > DPW) ? WW + 1 : DPW) + 1;
  localparam int PPW = WW + DW;

  logic signed [WW-1:0]  w_leak;
  logic signed [DPW-1:0] dprod;
  logic signed [DPW-1:0] delta;
  logic signed [DPW-1:0] delta_g;
  logic signed [SW-1:0]  upd;
  logic signed [PPW-1:0] pprod;

  // w - (w>>>sh) keeps the sign of w and never exceeds |w|, so it fits in WW.
  assign w_leak  = leak ? (w - (w >>> leak_sh)) : w;
  assign dprod   = DPW'(eu) * DPW'(x);
  assign delta   = dprod >>> FRAC;
  assign delta_g = adapt ? delta : '0;
  assign upd     = SW'(w_leak) + SW'(delta_g);
  assign w_new   = WW'(sat_s({{(SAT_IW-SW){upd[SW-1]}}, upd}, WW));
  assign pprod   = PPW'(w_new) * PPW'(x);
  assign prod    = pprod >>> FRAC;

endmodule

// File: rtl/lms_adapt_par.sv
// Parallel-lane LMS adaptive FIR. Each accepted sample updates all TAPS
// weights (LANES per cycle) and produces y = sum (w'[i]*x[i])>>>FRAC.
// Handshake: a sample transfers on a rising edge with in_valid && in_ready
// (in_ready only in IDLE; offers while busy are dropped, not queued); a
// result transfers with out_valid && out_ready, and out_valid/out_sample
// are held unchanged until then.
// Ports: clk, rst (async, active high); in_valid/in_ready/in_sample,
//   error_in, mu_in, adapt_en, leak_en, leak_sh, wclr (IDLE only);
//   out_valid/out_ready/out_sample; w_rd_idx -> w_rd_data (combinational
//   weight read); busy (state != IDLE); dbg_state (controller state).
module lms_adapt_par import lms_pkg::*; #(
  parameter int TAPS  = 128,
  parameter int LANES = 2,
  parameter int DW    = 16,
  parameter int WW    = 32,
  parameter int FRAC  = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            in_sample,
  input  logic [DW-1:0]            error_in,
  input  logic [DW-1:0]            mu_in,
  input  logic                     adapt_en,
  input  logic                     leak_en,
  input  logic [3:0]               leak_sh,
  input  logic                     wclr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WW-1:0]            out_sample,
  input  logic [$clog2(TAPS)-1:0]  w_rd_idx,
  output logic [WW-1:0]            w_rd_data,
  output logic                     busy,
  output logic [1:0]               dbg_state
);

  localparam int NGRP = TAPS / LANES;
  localparam int GW   = idx_width(NGRP);
  localparam int IW   = $clog2(TAPS);
  localparam int EUW  = 2 * DW;
  localparam int PPW  = WW + DW;
  localparam int ACCW = acc_width(WW, DW, TAPS);

  state_t               state;
  logic [GW-1:0]        grp;
  logic [1:0]           dcnt;
  logic signed [DW-1:0] x [TAPS];
  logic signed [WW-1:0] w [TAPS];

  logic                  adapt_r;
  logic                  leak_r;
  logic [3:0]            sh_r;
  logic signed [EUW-1:0] eu_r;
  logic signed [EUW-1:0] eu_full;
  logic signed [EUW-1:0] eu_next;

  logic                   p1_vld;
  logic signed [ACCW-1:0] p1_sum;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] lane_sum;
  logic signed [WW-1:0]   out_sat;

  logic [IW-1:0]         lane_idx [LANES];
  logic signed [WW-1:0]  lane_w_new [LANES];
  logic signed [PPW-1:0] lane_prod [LANES];

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;
  assign w_rd_data = w[w_rd_idx];

  assign eu_full = EUW'($signed(error_in)) * EUW'($signed(mu_in));
  assign eu_next = eu_full >>> FRAC;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l] = IW'(int'(grp) * LANES + l);
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lms_lane #(.DW(DW), .WW(WW), .FRAC(FRAC)) u_lane (
      .w       (w[lane_idx[g]]),
      .x       (x[lane_idx[g]]),
      .eu      (eu_r),
      .adapt   (adapt_r),
      .leak    (leak_r),
      .leak_sh (sh_r),
      .w_new   (lane_w_new[g]),
      .prod    (lane_prod[g])
    );
  end

  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_sum = lane_sum + ACCW'(lane_prod[l]);
    end
  end

  assign out_sat = WW'(sat_s({{(SAT_IW-ACCW){acc[ACCW-1]}}, acc}, WW));

  // Pipeline: lane sums registered in the issuing RUN cycle (p1), folded
  // into acc one cycle later; DRAIN waits DRAIN_CYCLES before presenting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      grp        <= '0;
      dcnt       <= '0;
      adapt_r    <= 1'b0;
      leak_r     <= 1'b0;
      sh_r       <= '0;
      eu_r       <= '0;
      p1_vld     <= 1'b0;
      p1_sum     <= '0;
      acc        <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
      for (int i = 0; i < TAPS; i++) begin
        x[i] <= '0;
        w[i] <= '0;
      end
    end else begin
      p1_vld <= (state == S_RUN);
      p1_sum <= lane_sum;
      if (p1_vld) acc <= acc + p1_sum;
      case (state)
        S_IDLE: begin
          // Clear precedes a coinciding acceptance: RUN starts next cycle
          // and therefore sees the zeroed weights.
          if (wclr) begin
            for (int i = 0; i < TAPS; i++) w[i] <= '0;
          end
          if (in_valid) begin
            for (int i = TAPS - 1; i > 0; i--) x[i] <= x[i-1];
            x[0]    <= in_sample;
            adapt_r <= adapt_en;
            leak_r  <= leak_en;
            sh_r    <= leak_sh;
            eu_r    <= eu_next;
            grp     <= '0;
            acc     <= '0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          for (int l = 0; l < LANES; l++) w[lane_idx[l]] <= lane_w_new[l];
          grp <= grp + 1'b1;
          if (grp == GW'(NGRP - 1)) begin
            dcnt  <= '0;
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          dcnt <= dcnt + 1'b1;
          if (dcnt == 2'(DRAIN_CYCLES - 1)) begin
            out_valid  <= 1'b1;
            out_sample <= out_sat;
            state      <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lms_adapt_par.sv
module tb_lms_adapt_par;

  localparam int TAPS  = 8;
  localparam int LANES = 2;
  localparam int DW    = 16;
  localparam int WW    = 32;
  localparam int FRAC  = 15;
  localparam int LAT   = TAPS / LANES + 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_sample;
  logic [DW-1:0] error_in;
  logic [DW-1:0] mu_in;
  logic          adapt_en;
  logic          leak_en;
  logic [3:0]    leak_sh;
  logic          wclr;
  logic          out_valid;
  logic          out_ready;
  logic [WW-1:0] out_sample;
  logic [2:0]    w_rd_idx;
  logic [WW-1:0] w_rd_data;
  logic          busy;
  logic [1:0]    dbg_state;

  lms_adapt_par #(.TAPS(TAPS), .LANES(LANES), .DW(DW), .WW(WW), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sample(in_sample), .error_in(error_in), .mu_in(mu_in),
    .adapt_en(adapt_en), .leak_en(leak_en), .leak_sh(leak_sh), .wclr(wclr),
    .out_valid(out_valid), .out_ready(out_ready), .out_sample(out_sample),
    .w_rd_idx(w_rd_idx), .w_rd_data(w_rd_data), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [WW-1:0] exp_q[$];

  // reference model: weights and x history as plain integers
  longint mw[TAPS];
  longint mx[TAPS];

  function automatic longint sat_ww(input longint v);
    longint hi, lo;
    hi = 64'sd2147483647;
    lo = -64'sd2147483648;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_clear_w();
    for (int i = 0; i < TAPS; i++) mw[i] = 0;
  endtask

  task automatic model_step(input longint xs, input longint es, input longint mus,
                            input bit ad, input bit lk, input int sh, input bit clr,
                            output longint y);
    longint eu, wn;
    if (clr) model_clear_w();
    for (int i = TAPS - 1; i > 0; i--) mx[i] = mx[i-1];
    mx[0] = xs;
    eu = (es * mus) >>> FRAC;
    y = 0;
    for (int i = 0; i < TAPS; i++) begin
      wn = mw[i];
      if (lk) wn = wn - (mw[i] >>> sh);
      if (ad) wn = wn + ((eu * mx[i]) >>> FRAC);
      mw[i] = sat_ww(wn);
      y = y + ((mw[i] * mx[i]) >>> FRAC);
    end
    y = sat_ww(y);
  endtask

  task automatic chk(input string nm, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // driver tasks
  task automatic send(input logic [DW-1:0] xi, input logic [DW-1:0] ei, input logic [DW-1:0] mi,
                      input bit ad, input bit lk, input logic [3:0] sh, input bit clr);
    int guard;
    longint y;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_ready: in_ready=0 after %0d cycles, required 1", guard);
    end
    in_sample = xi; error_in = ei; mu_in = mi;
    adapt_en = ad; leak_en = lk; leak_sh = sh; wclr = clr;
    in_valid = 1'b1;
    model_step(longint'($signed(xi)), longint'($signed(ei)), longint'($signed(mi)),
               ad, lk, int'(sh), clr, y);
    exp_q.push_back(WW'(y));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wclr = 1'b0;
  endtask

  task automatic wait_out(input string nm, output int lat);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    chk({nm, "_out_valid"}, longint'(out_valid), 1);
  endtask

  // scoreboard: compare the presented result with the oldest expected value
  task automatic check_out(input string nm);
    logic [WW-1:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_sb: result with empty expected queue, got %0d", nm, $signed(out_sample));
    end else begin
      e = exp_q.pop_front();
      chk({nm, "_y"}, longint'($signed(out_sample)), longint'($signed(e)));
    end
  endtask

  task automatic release_out(input string nm);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({nm, "_idle_after_out"}, longint'(in_ready), 1);
  endtask

  task automatic check_weights(input string nm);
    for (int i = 0; i < TAPS; i++) begin
      w_rd_idx = 3'(i);
      #1;
      chk($sformatf("%s_w%0d", nm, i), longint'($signed(w_rd_data)), mw[i]);
    end
  endtask

  typedef struct {
    logic [DW-1:0] x;
    logic [DW-1:0] e;
    logic [DW-1:0] mu;
    bit            ad;
    bit            lk;
    logic [3:0]    sh;
    longint        y;
    longint        w0;
    longint        w1;
  } vec_t;

  vec_t vt[3];

  initial begin
    int lat;
    int hits;
    logic [WW-1:0] held;
    logic [DW-1:0] rx, re, rm;

    vt[0] = '{16'h4000, 16'h4000, 16'h4000, 1'b1, 1'b0, 4'd0, 2048, 4096, 0};
    vt[1] = '{16'h4000, 16'h4000, 16'h4000, 1'b0, 1'b0, 4'd0, 2048, 4096, 0};
    vt[2] = '{16'h4000, 16'h0000, 16'h4000, 1'b1, 1'b1, 4'd4, 1920, 3840, 0};

    rst = 1'b1; in_valid = 0; in_sample = 0; error_in = 0; mu_in = 0;
    adapt_en = 0; leak_en = 0; leak_sh = 0; wclr = 0; out_ready = 0; w_rd_idx = 0;
    for (int i = 0; i < TAPS; i++) begin mw[i] = 0; mx[i] = 0; end

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_sample", longint'(out_sample), 0);
    check_weights("rst");
    @(negedge clk);
    rst = 1'b0;

    // directed table
    for (int k = 0; k < 3; k++) begin
      send(vt[k].x, vt[k].e, vt[k].mu, vt[k].ad, vt[k].lk, vt[k].sh, 1'b0);
      wait_out($sformatf("vec%0d", k), lat);
      chk($sformatf("vec%0d_latency", k), lat, LAT);
      chk($sformatf("vec%0d_table_y", k), longint'($signed(out_sample)), vt[k].y);
      check_out($sformatf("vec%0d", k));
      w_rd_idx = 3'd0; #1;
      chk($sformatf("vec%0d_table_w0", k), longint'($signed(w_rd_data)), vt[k].w0);
      w_rd_idx = 3'd1; #1;
      chk($sformatf("vec%0d_table_w1", k), longint'($signed(w_rd_data)), vt[k].w1);
      if (k == 2) begin
        // hold result with out_ready low; an in_valid offer must be dropped
        held = out_sample;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          in_sample = 16'h7fff;
          in_valid = (c == 2);
          chk($sformatf("hold%0d_valid", c), longint'(out_valid), 1);
          chk($sformatf("hold%0d_sample", c), longint'(out_sample), longint'(held));
          chk($sformatf("hold%0d_in_ready", c), longint'(in_ready), 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      release_out($sformatf("vec%0d", k));
    end

    // randomized samples against the model; the first also exposes any
    // history corruption by the dropped offer above
    for (int k = 0; k < 16; k++) begin
      rx = DW'($urandom);
      re = DW'($urandom);
      rm = (k % 4 == 3) ? 16'h8000 : DW'($urandom);
      send(rx, re, rm, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
           4'($urandom_range(0, 15)), 1'b0);
      wait_out($sformatf("rnd%0d", k), lat);
      chk($sformatf("rnd%0d_latency", k), lat, LAT);
      check_out($sformatf("rnd%0d", k));
      check_weights($sformatf("rnd%0d", k));
      release_out($sformatf("rnd%0d", k));
    end

    // reset asserted in RUN cycle 2 aborts the operation
    send(16'h4000, 16'h4000, 16'h4000, 1'b1, 1'b0, 4'd0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_state_run", longint'(dbg_state), 1);
    rst = 1'b1;
    #1;
    for (int i = 0; i < TAPS; i++) begin mw[i] = 0; mx[i] = 0; end
    exp_q.delete();
    chk("abort_out_valid", longint'(out_valid), 0);
    chk("abort_busy", longint'(busy), 0);
    chk("abort_out_sample", longint'(out_sample), 0);
    check_weights("abort");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_in_ready", longint'(in_ready), 1);
    hits = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) hits++;
    end
    chk("abort_no_result", hits, 0);

    // wclr alone in IDLE, then a non-adapting sample sees zero weights
    send(16'h4000, 16'h4000, 16'h4000, 1'b1, 1'b0, 4'd0, 1'b0);
    wait_out("pre_clr", lat);
    check_out("pre_clr");
    check_weights("pre_clr");
    release_out("pre_clr");
    @(negedge clk);
    wclr = 1'b1;
    @(posedge clk); #1;
    wclr = 1'b0;
    model_clear_w();
    check_weights("wclr");
    send(16'h4000, 16'h4000, 16'h4000, 1'b0, 1'b0, 4'd0, 1'b0);
    wait_out("post_clr", lat);
    chk("post_clr_y_zero", longint'($signed(out_sample)), 0);
    check_out("post_clr");
    release_out("post_clr");

    // wclr coinciding with an accepted sample: clear first, then update
    send(16'h2000, 16'h4000, 16'h4000, 1'b1, 1'b0, 4'd0, 1'b0);
    wait_out("pre_co", lat);
    check_out("pre_co");
    release_out("pre_co");
    send(16'hc000, 16'h3000, 16'h5000, 1'b1, 1'b0, 4'd0, 1'b1);
    wait_out("co_clr", lat);
    check_out("co_clr");
    check_weights("co_clr");
    release_out("co_clr");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lms_adapt_par.md
LMS_ADAPT_PAR -- requirements
Module: lms_adapt_par

Interface
REQ-001 SHALL have parameter TAPS, default 128, filter length; must be a multiple of LANES.
REQ-002 SHALL have parameter LANES, default 2, taps processed per cycle; must be a power of 2 and at most TAPS.
REQ-003 SHALL have parameter DW, default 16, sample/error/mu width, Q1.(DW-1).
REQ-004 SHALL have parameter WW, default 32, weight/output width, fixed-point Q(WW-FRAC).FRAC.
REQ-005 SHALL have parameter FRAC, default 15, fractional bits.
REQ-006 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port in_valid, input, 1, new sample offered.
REQ-009 SHALL have port in_ready, output, 1, block can accept a sample.
REQ-010 SHALL have port in_sample, input, DW, signed reference sample x.
REQ-011 SHALL have port error_in, input, DW, signed error e.
REQ-012 SHALL have port mu_in, input, DW, signed step size.
REQ-013 SHALL have port adapt_en, input, 1, enable weight update.
REQ-014 SHALL have port leak_en, input, 1, enable leakage.
REQ-015 SHALL have port leak_sh, input, 4, leakage shift.
REQ-016 SHALL have port wclr, input, 1, clear all weights (honoured in IDLE only).
REQ-017 SHALL have port out_valid, output, 1, result available.
REQ-018 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-019 SHALL have port out_sample, output, WW, signed filter output y.
REQ-020 SHALL have port w_rd_idx, input, clog2(TAPS), weight debug read index.
REQ-021 SHALL have port w_rd_data, output, WW, combinational read of w[w_rd_idx].
REQ-022 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-023 SHALL use FSM states IDLE, RUN, DRAIN, OUT; in_ready = (state==IDLE).
REQ-024 A sample SHALL be accepted when in_valid && in_ready; on acceptance the block SHALL shift x history (x[0] = in_sample, x[i] = x[i-1]), latch adapt_en, leak_en and leak_sh, compute eu = (error_in*mu_in)>>>FRAC, and enter RUN.
REQ-025 RUN SHALL last TAPS/LANES cycles, issuing taps j*LANES .. j*LANES+LANES-1 in cycle j.
REQ-026 Per tap i, the new weight SHALL be computed as: w' = w; if leak_en, w' = w - (w>>>leak_sh); if adapt_en, w' = w' + ((eu*x[i])>>>FRAC); the result SHALL saturate to the signed WW range.
REQ-027 The output SHALL be y = sum over i of (w'[i]*x[i])>>>FRAC, using updated weights, with full-precision accumulator width WW+DW+clog2(TAPS).
REQ-028 out_sample SHALL be the accumulator saturated to the signed WW range.
REQ-029 DRAIN SHALL flush the fixed pipeline; out_valid SHALL rise exactly TAPS/LANES+4 cycles after the acceptance edge.
REQ-030 In OUT, out_valid and out_sample SHALL be held stable until out_ready; the transition to IDLE SHALL occur on the cycle after out_valid && out_ready.
REQ-031 in_valid SHALL be ignored while busy; samples offered at that time are not queued.
REQ-032 wclr in IDLE SHALL zero all weights in one cycle; if wclr and an accepted sample coincide, the clear SHALL apply first and processing then uses zero weights.
REQ-033 All arithmetic shifts SHALL be arithmetic (floor) with no rounding.

Reset
REQ-034 While rst is high, state SHALL be IDLE, all weights and x history SHALL be zero, and out_valid, busy and out_sample SHALL be 0.
REQ-035 Assertion of rst mid-RUN/DRAIN/OUT SHALL abort the operation immediately; no partial result SHALL appear.

Structure
REQ-036 Package lms_pkg SHALL hold the FSM state enum, the saturation function, and the clog2-derived width constants.
REQ-037 Each lane SHALL be a sub-module lms_lane (delta, leak, saturate update, product) instantiated LANES times.

Verification (TAPS=8, LANES=2, defaults otherwise)
REQ-038 After reset, apply x=e=mu=0x4000 with adapt_en=1: out_sample=2048, w[0]=4096, and out_valid at acceptance +8 cycles.
REQ-039 Next sample x=0x4000 with adapt_en=0: out_sample=2048, w[0]=4096, w[1]=0.
REQ-040 Then apply e=0, leak_en=1, leak_sh=4: w[0]=3840.
REQ-041 Hold out_ready=0 for 5 cycles: out_valid and out_sample stay stable, in_ready=0, and an in_valid pulse is ignored (x history is unchanged).
REQ-042 Assert rst in RUN cycle 2: out_valid=0, all weights=0, and in_ready=1 after release.
REQ-043 Pulse wclr in IDLE, then apply sample x=0x4000 with adapt_en=0: out_sample=0.
